reduce_ctrl: RTL and testbench
==============================

# reduce_ctrl

Sequencing controller that runs multi-sample reductions (sum, max, min, sum-of-absolute-values) on the shared ALU adder. It uses the adder's existing function-code interface (ADD/SUB/CMP/ABS encodings) and does not duplicate arithmetic. The block owns the accumulator, sample counter and input handshake. It sits between the sample stream and the adder, driving the adder's function code and operands and capturing the adder result each cycle.

## Interface
- W, 32: data/accumulator width.
- LEN_W, 8: width of the sample-count field.
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  start a reduction. Sampled only in IDLE.
- abort_i  in  1  synchronous abort to IDLE, no done_o. Highest priority after reset.
- mode_i  in  2  00 SUM, 01 MAX, 10 MIN, 11 SUMABS. Latched on start.
- len_i  in  LEN_W  number of samples (0 allowed). Latched on start.
- in_valid_i  in  1  sample valid.
- in_data_i  in  W  signed sample.
- in_ready_o  out  1  sample accepted when in_valid_i & in_ready_o.
- function_o  out  3  adder function code: 000 ADD, 010 SUB, 100 ABS.
- opa_o, opb_o  out  W  adder operands.
- result_i  in  W+1  adder result. It is the exact combinational result of sign-extended operands in the same cycle. ADD: a+b. SUB: b−a. ABS: |a| (with opb=0).
- busy_o  out  1  state ≠ IDLE.
- done_o  out  1  one-cycle pulse, reduction complete.
- result_o  out  W  accumulator value.
- ovf_o  out  1  sticky overflow for the current reduction.

## Operation
- States: IDLE, RUN, ACC2 (SUMABS second phase), DONE.
- Default drive (IDLE, DONE, and RUN without handshake): function_o=000, opa_o=opb_o=0, in_ready_o=0. One exception: in RUN, in_ready_o=1.
- IDLE with start_i=1:
  - latch mode_i and len_i into cnt
  - acc=0, ovf=0, first=1
  - go to DONE if len_i==0, else go to RUN
- RUN, SUM, on accept: function 000, opa=acc, opb=in_data. acc←result_i[W−1:0].
- RUN, MAX/MIN, on accept:
  - If first=1: function 000, opa=0, opb=in_data. acc←result_i[W−1:0]. first←0.
  - Otherwise: function 010, opa=acc, opb=in_data, giving in_data−acc. Update acc←in_data when MAX and result_i[W]=0 (ties take the new sample), or when MIN and result_i[W]=1. Otherwise acc holds.
- RUN, SUMABS, on accept: function 100, opa=in_data, opb=0. tmp←result_i[W−1:0]. Go to ACC2.
- ACC2: function 000, opa=acc, opb=tmp, in_ready_o=0. acc←result_i[W−1:0].
- Counter: cnt decrements on every accept.
  - SUM/MAX/MIN: an accept with cnt==1 goes to DONE. Otherwise stay in RUN.
  - SUMABS: ACC2 goes to DONE when cnt==0, else back to RUN.
- Overflow: ovf←1 on any cycle where acc or tmp is written from result_i and result_i[W]≠result_i[W−1]. Stored values wrap; there is no saturation. |−2^(W−1)| therefore stores −2^(W−1) and sets ovf.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- result_o = acc at all times. It holds after DONE until the next start clears it.
- start_i while busy_o=1 is ignored.
- abort_i in any state: next state IDLE, no done_o. acc and ovf hold their values.

## Timing
- Reset values:
  - state IDLE
  - acc, tmp, cnt = 0
  - ovf = 0
  - first = 0
  - busy_o, done_o, in_ready_o = 0
  - function_o = 000
  - opa_o, opb_o = 0
  - result_o = 0
- Reset is asynchronous and can occur mid-operation. All of the above apply immediately. A partially accepted sample is lost.
- Start accepted at edge 0 → busy_o high from cycle 1.
- SUM/MAX/MIN with in_valid_i held high: one sample per cycle in cycles 1..N. done_o in cycle N+1. busy_o falls in cycle N+2.
- SUMABS: accepts in cycles 1,3,…,2N−1. ACC2 in 2,4,…,2N. done_o in cycle 2N+1.
- len_i=0: done_o in cycle 1, result_o=0.
- in_valid_i gaps: RUN waits with no state change.
- function_o/opa_o/opb_o are combinational from state, acc, tmp and in_data_i.
- A result_i path that is not same-cycle is out of scope.

## Test plan
- SUM, len=4, samples 1,2,3,4 back-to-back → done_o in cycle 5, result_o=10, ovf_o=0. Insert one in_valid_i gap → done_o in cycle 6, same result.
- MAX on −5,7,7,−1 → 7. MIN on the same samples → −5. Check function_o=010 on non-first samples and 000 on the first.
- SUMABS, len=3, samples −3,4,−2 → result_o=9, done_o in cycle 7, in_ready_o alternating 1,0. With W=32, a sample of 0x8000_0000 → ovf_o=1.
- SUM 0x7FFF_FFFF+1 → result_o=0x8000_0000, ovf_o=1. A following start clears ovf_o to 0.
- Control cases:
  - len=0 → done_o in cycle 1, result_o=0.
  - start_i while busy → ignored.
  - abort_i mid-RUN → IDLE next cycle, no done_o.
- reset_i asserted asynchronously mid-SUMABS (in ACC2) → all outputs at reset values before the next clock edge. A following start works normally.

Source files
------------

// File: rtl/reduce_ctrl_if.sv
// Control, sample-stream and shared-adder signal bundle for reduce_ctrl.
// slave is the controller's view; master is the view of whatever drives it.
interface reduce_ctrl_if #(
   parameter int W     = 32,
   parameter int LEN_W = 8
);
   logic             start_i;
   logic             abort_i;
   logic [1:0]       mode_i;
   logic [LEN_W-1:0] len_i;
   logic             in_valid_i;
   logic [W-1:0]     in_data_i;
   logic             in_ready_o;
   logic [2:0]       function_o;
   logic [W-1:0]     opa_o;
   logic [W-1:0]     opb_o;
   logic [W:0]       result_i;
   logic             busy_o;
   logic             done_o;
   logic [W-1:0]     result_o;
   logic             ovf_o;

   modport slave (
      input  start_i, abort_i, mode_i, len_i, in_valid_i, in_data_i, result_i,
      output in_ready_o, function_o, opa_o, opb_o, busy_o, done_o, result_o, ovf_o
   );

   modport master (
      output start_i, abort_i, mode_i, len_i, in_valid_i, in_data_i, result_i,
      input  in_ready_o, function_o, opa_o, opb_o, busy_o, done_o, result_o, ovf_o
   );
endinterface

// File: rtl/reduce_ctrl.sv
// Runs SUM/MAX/MIN/SUMABS reductions through the shared adder: one sample per cycle
// (SUMABS one per two cycles); in_ready_o high only in RUN, done_o pulses one cycle after the last update.
module reduce_ctrl #(
   parameter int W     = 32,
   parameter int LEN_W = 8
) (
   input logic          clk_i,
   input logic          reset_i,
   reduce_ctrl_if.slave bus
);

   localparam logic [1:0] M_SUM    = 2'b00;
   localparam logic [1:0] M_MAX    = 2'b01;
   localparam logic [1:0] M_MIN    = 2'b10;
   localparam logic [1:0] M_SUMABS = 2'b11;

   localparam logic [2:0] FN_ADD = 3'b000;
   localparam logic [2:0] FN_SUB = 3'b010;
   localparam logic [2:0] FN_ABS = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_ACC2 = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           r_state;
   logic [1:0]       r_mode;
   logic [LEN_W-1:0] r_cnt;
   logic [W-1:0]     r_acc;
   logic [W-1:0]     r_tmp;
   logic             r_ovf;
   logic             r_first;

   logic             w_accept;
   logic [2:0]       w_fn;
   logic [W-1:0]     w_opa;
   logic [W-1:0]     w_opb;
   logic [W-1:0]     w_res;
   logic             w_res_ovf;
   logic             w_res_neg;
   logic             w_last;

   assign w_accept  = (r_state == S_RUN) && bus.in_valid_i;
   assign w_res     = bus.result_i[W-1:0];
   assign w_res_neg = bus.result_i[W];
   assign w_res_ovf = bus.result_i[W] ^ bus.result_i[W-1];
   assign w_last    = (r_cnt == LEN_W'(1));

   // Operand steering is combinational so the adder result comes back in the same cycle.
   always_comb begin
      w_fn  = FN_ADD;
      w_opa = '0;
      w_opb = '0;
      if (w_accept) begin
         case (r_mode)
            M_SUM: begin
               w_opa = r_acc;
               w_opb = bus.in_data_i;
            end
            M_MAX, M_MIN: begin
               w_opb = bus.in_data_i;
               if (!r_first) begin
                  w_fn  = FN_SUB;
                  w_opa = r_acc;
               end
            end
            default: begin
               w_fn  = FN_ABS;
               w_opa = bus.in_data_i;
            end
         endcase
      end else if (r_state == S_ACC2) begin
         w_opa = r_acc;
         w_opb = r_tmp;
      end
   end

   assign bus.function_o = w_fn;
   assign bus.opa_o      = w_opa;
   assign bus.opb_o      = w_opb;
   assign bus.in_ready_o = (r_state == S_RUN);
   assign bus.busy_o     = (r_state != S_IDLE);
   assign bus.done_o     = (r_state == S_DONE);
   assign bus.result_o   = r_acc;
   assign bus.ovf_o      = r_ovf;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state <= S_IDLE;
         r_mode  <= M_SUM;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_tmp   <= '0;
         r_ovf   <= 1'b0;
         r_first <= 1'b0;
      end else if (bus.abort_i) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start_i) begin
                  r_mode  <= bus.mode_i;
                  r_cnt   <= bus.len_i;
                  r_acc   <= '0;
                  r_ovf   <= 1'b0;
                  r_first <= 1'b1;
                  r_state <= (bus.len_i == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (w_accept) begin
                  r_cnt <= r_cnt - LEN_W'(1);
                  case (r_mode)
                     M_SUM: begin
                        r_acc <= w_res;
                        r_ovf <= r_ovf | w_res_ovf;
                        if (w_last) r_state <= S_DONE;
                     end
                     M_MAX, M_MIN: begin
                        if (r_first) begin
                           r_acc   <= w_res;
                           r_ovf   <= r_ovf | w_res_ovf;
                           r_first <= 1'b0;
                        end else if ((r_mode == M_MAX && !w_res_neg) ||
                                     (r_mode == M_MIN &&  w_res_neg)) begin
                           // Sign of (sample - acc) picks the winner; MAX ties take the new sample.
                           r_acc <= bus.in_data_i;
                        end
                        if (w_last) r_state <= S_DONE;
                     end
                     default: begin
                        r_tmp   <= w_res;
                        r_ovf   <= r_ovf | w_res_ovf;
                        r_state <= S_ACC2;
                     end
                  endcase
               end
            end
            S_ACC2: begin
               r_acc   <= w_res;
               r_ovf   <= r_ovf | w_res_ovf;
               r_state <= (r_cnt == '0) ? S_DONE : S_RUN;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reduce_ctrl.sv
// Self-checking bench for reduce_ctrl: directed scenarios plus randomized reductions
// compared against an arithmetic reference model; the shared adder is modelled here.
module tb_reduce_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   reduce_ctrl_if #(.W(32), .LEN_W(8)) bus ();

   reduce_ctrl #(.W(32), .LEN_W(8)) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Shared adder: exact result on sign-extended operands.
   function automatic logic [32:0] adder(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [32:0] sa;
      logic signed [32:0] sb;
      sa = {a[31], a};
      sb = {b[31], b};
      case (f)
         3'b000:  return sa + sb;
         3'b010:  return sb - sa;
         3'b100:  return sa[32] ? -sa : sa;
         default: return '0;
      endcase
   endfunction

   assign bus.result_i = adder(bus.function_o, bus.opa_o, bus.opb_o);

   logic [31:0] g_smp[$];
   logic [2:0]  g_fn[$];
   logic        g_rdy[$];
   int          g_done_cyc;
   int          g_last_acc;
   int          g_gap_at = -1;
   int          g_gap_pct = 0;
   bit          g_hold_start = 1'b0;
   logic [31:0] g_res;
   logic        g_ovf;

   function automatic longint wrap32(input longint v);
      logic [31:0] t;
      t = v[31:0];
      return longint'($signed(t));
   endfunction

   // Reference: reduction computed directly from the sample list with wide arithmetic.
   task automatic model(input logic [1:0] mode, output logic [31:0] r, output logic o);
      longint acc;
      longint x;
      longint a;
      longint s;
      acc = 0;
      o   = 1'b0;
      for (int i = 0; i < g_smp.size(); i++) begin
         x = longint'($signed(g_smp[i]));
         case (mode)
            2'b00: begin
               s = acc + x;
               if (s > 64'sd2147483647 || s < -64'sd2147483648) o = 1'b1;
               acc = wrap32(s);
            end
            2'b01: acc = (i == 0 || x >= acc) ? x : acc;
            2'b10: acc = (i == 0 || x < acc) ? x : acc;
            default: begin
               a = (x < 0) ? -x : x;
               if (a > 64'sd2147483647) o = 1'b1;
               a = wrap32(a);
               s = acc + a;
               if (s > 64'sd2147483647 || s < -64'sd2147483648) o = 1'b1;
               acc = wrap32(s);
            end
         endcase
      end
      r = acc[31:0];
   endtask

   task automatic drive_idle();
      bus.start_i    = 1'b0;
      bus.abort_i    = 1'b0;
      bus.mode_i     = 2'b00;
      bus.len_i      = '0;
      bus.in_valid_i = 1'b0;
      bus.in_data_i  = '0;
   endtask

   // Starts one reduction over g_smp and feeds it; cycle 1 is the cycle after the start edge.
   task automatic run_red(input logic [1:0] mode, input int len);
      int idx;
      bit v;
      idx = 0;
      g_fn.delete();
      g_rdy.delete();
      g_done_cyc = -1;
      g_last_acc = 0;
      @(posedge clk); #1;
      bus.start_i = 1'b1;
      bus.mode_i  = mode;
      bus.len_i   = len[7:0];
      @(posedge clk); #1;
      if (!g_hold_start) bus.start_i = 1'b0;
      bus.mode_i = 2'($urandom);
      bus.len_i  = 8'($urandom);
      for (int c = 1; c <= 400; c++) begin
         v = (idx < g_smp.size()) && (c != g_gap_at) && ($urandom_range(99) >= g_gap_pct);
         bus.in_valid_i = v;
         bus.in_data_i  = v ? g_smp[idx] : $urandom;
         @(negedge clk);
         if (bus.busy_o && !bus.done_o) g_rdy.push_back(bus.in_ready_o);
         if (v && bus.in_ready_o) begin
            g_fn.push_back(bus.function_o);
            idx++;
            g_last_acc = c;
         end
         if (bus.done_o) begin
            g_done_cyc = c;
            g_res      = bus.result_o;
            g_ovf      = bus.ovf_o;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      bus.start_i    = 1'b0;
      bus.in_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks += 8;
      if (bus.busy_o !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy_o); end
      if (bus.done_o !== 1'b0)      begin errors++; $display("FAIL reset_done got=%b want=0", bus.done_o); end
      if (bus.in_ready_o !== 1'b0)  begin errors++; $display("FAIL reset_ready got=%b want=0", bus.in_ready_o); end
      if (bus.function_o !== 3'b0)  begin errors++; $display("FAIL reset_fn got=%b want=000", bus.function_o); end
      if (bus.opa_o !== 32'h0)      begin errors++; $display("FAIL reset_opa got=%h want=0", bus.opa_o); end
      if (bus.opb_o !== 32'h0)      begin errors++; $display("FAIL reset_opb got=%h want=0", bus.opb_o); end
      if (bus.result_o !== 32'h0)   begin errors++; $display("FAIL reset_result got=%h want=0", bus.result_o); end
      if (bus.ovf_o !== 1'b0)       begin errors++; $display("FAIL reset_ovf got=%b want=0", bus.ovf_o); end
      rst = 1'b0;
   endtask

   task automatic test_sum();
      g_smp = '{32'd1, 32'd2, 32'd3, 32'd4};
      run_red(2'b00, 4);
      checks += 3;
      if (g_done_cyc !== 5)    begin errors++; $display("FAIL sum_done_cycle got=%0d want=5", g_done_cyc); end
      if (g_res !== 32'd10)    begin errors++; $display("FAIL sum_result got=%0d want=10", g_res); end
      if (g_ovf !== 1'b0)      begin errors++; $display("FAIL sum_ovf got=%b want=0", g_ovf); end
      g_gap_at = 2;
      run_red(2'b00, 4);
      g_gap_at = -1;
      checks += 2;
      if (g_done_cyc !== 6)    begin errors++; $display("FAIL sum_gap_done_cycle got=%0d want=6", g_done_cyc); end
      if (g_res !== 32'd10)    begin errors++; $display("FAIL sum_gap_result got=%0d want=10", g_res); end
   endtask

   task automatic test_maxmin();
      g_smp = '{-32'sd5, 32'sd7, 32'sd7, -32'sd1};
      run_red(2'b01, 4);
      checks += 2;
      if (g_res !== 32'd7)     begin errors++; $display("FAIL max_result got=%0d want=7", $signed(g_res)); end
      if (g_fn.size() != 4 || g_fn[0] !== 3'b000) begin
         errors++; $display("FAIL max_fn_first got=%b want=000 (n=%0d)", (g_fn.size() > 0) ? g_fn[0] : 3'bx, g_fn.size());
      end
      for (int i = 1; i < g_fn.size(); i++) begin
         checks++;
         if (g_fn[i] !== 3'b010) begin errors++; $display("FAIL max_fn_%0d got=%b want=010", i, g_fn[i]); end
      end
      run_red(2'b10, 4);
      checks += 2;
      if (g_res !== 32'hFFFF_FFFB) begin errors++; $display("FAIL min_result got=%0d want=-5", $signed(g_res)); end
      if (g_done_cyc !== 5)    begin errors++; $display("FAIL min_done_cycle got=%0d want=5", g_done_cyc); end
   endtask

   task automatic test_sumabs();
      g_smp = '{-32'sd3, 32'sd4, -32'sd2};
      run_red(2'b11, 3);
      checks += 4;
      if (g_res !== 32'd9)     begin errors++; $display("FAIL sumabs_result got=%0d want=9", g_res); end
      if (g_done_cyc !== 7)    begin errors++; $display("FAIL sumabs_done_cycle got=%0d want=7", g_done_cyc); end
      if (g_ovf !== 1'b0)      begin errors++; $display("FAIL sumabs_ovf got=%b want=0", g_ovf); end
      if (g_rdy.size() != 6)   begin errors++; $display("FAIL sumabs_busy_cycles got=%0d want=6", g_rdy.size()); end
      for (int i = 0; i < g_rdy.size() && i < 6; i++) begin
         checks++;
         if (g_rdy[i] !== ((i % 2) == 0)) begin
            errors++; $display("FAIL sumabs_ready_c%0d got=%b want=%b", i + 1, g_rdy[i], ((i % 2) == 0));
         end
      end
      g_smp = '{32'h8000_0000};
      run_red(2'b11, 1);
      checks += 2;
      if (g_res !== 32'h8000_0000) begin errors++; $display("FAIL sumabs_min_result got=%h want=80000000", g_res); end
      if (g_ovf !== 1'b1)      begin errors++; $display("FAIL sumabs_min_ovf got=%b want=1", g_ovf); end
   endtask

   task automatic test_ovf();
      g_smp = '{32'h7FFF_FFFF, 32'h1};
      run_red(2'b00, 2);
      checks += 2;
      if (g_res !== 32'h8000_0000) begin errors++; $display("FAIL ovf_result got=%h want=80000000", g_res); end
      if (g_ovf !== 1'b1)      begin errors++; $display("FAIL ovf_flag got=%b want=1", g_ovf); end
      g_smp = '{32'd5};
      run_red(2'b00, 1);
      checks += 2;
      if (g_ovf !== 1'b0)      begin errors++; $display("FAIL ovf_clear got=%b want=0", g_ovf); end
      if (g_res !== 32'd5)     begin errors++; $display("FAIL ovf_next_result got=%0d want=5", g_res); end
   endtask

   task automatic test_len0();
      g_smp.delete();
      run_red(2'b00, 0);
      checks += 2;
      if (g_done_cyc !== 1)    begin errors++; $display("FAIL len0_done_cycle got=%0d want=1", g_done_cyc); end
      if (g_res !== 32'd0)     begin errors++; $display("FAIL len0_result got=%0d want=0", g_res); end
   endtask

   task automatic test_start_busy();
      g_smp = '{32'd1, 32'd1, 32'd1};
      g_hold_start = 1'b1;
      run_red(2'b00, 3);
      g_hold_start = 1'b0;
      checks += 2;
      if (g_done_cyc !== 4)    begin errors++; $display("FAIL busy_start_done_cycle got=%0d want=4", g_done_cyc); end
      if (g_res !== 32'd3)     begin errors++; $display("FAIL busy_start_result got=%0d want=3", g_res); end
   endtask

   task automatic test_abort();
      bit seen_done;
      seen_done = 1'b0;
      @(posedge clk); #1;
      bus.start_i = 1'b1; bus.mode_i = 2'b00; bus.len_i = 8'd4;
      @(posedge clk); #1;
      bus.start_i = 1'b0; bus.in_valid_i = 1'b1; bus.in_data_i = 32'd1;
      @(posedge clk); #1;
      bus.in_data_i = 32'd2;
      @(posedge clk); #1;
      bus.abort_i = 1'b1; bus.in_data_i = 32'd100;
      @(negedge clk);
      checks++;
      if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL abort_pre_busy got=%b want=1", bus.busy_o); end
      @(posedge clk); #1;
      bus.abort_i = 1'b0; bus.in_valid_i = 1'b0;
      checks += 3;
      if (bus.busy_o !== 1'b0)     begin errors++; $display("FAIL abort_busy got=%b want=0", bus.busy_o); end
      if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL abort_ready got=%b want=0", bus.in_ready_o); end
      if (bus.result_o !== 32'd3)  begin errors++; $display("FAIL abort_acc_hold got=%0d want=3", bus.result_o); end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.done_o) seen_done = 1'b1;
      end
      checks++;
      if (seen_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got=%b want=0", seen_done); end
   endtask

   task automatic test_async_reset();
      @(posedge clk); #1;
      bus.start_i = 1'b1; bus.mode_i = 2'b11; bus.len_i = 8'd3;
      @(posedge clk); #1;
      bus.start_i = 1'b0; bus.in_valid_i = 1'b1; bus.in_data_i = -32'sd3;
      @(posedge clk); #1;
      bus.in_data_i = 32'sd4;
      @(posedge clk); #1;
      @(posedge clk); #2;
      checks += 2;
      if (!(bus.busy_o === 1'b1 && bus.in_ready_o === 1'b0)) begin
         errors++; $display("FAIL areset_pre_acc2 got busy=%b ready=%b want busy=1 ready=0", bus.busy_o, bus.in_ready_o);
      end
      if (bus.result_o !== 32'd3) begin errors++; $display("FAIL areset_pre_acc got=%0d want=3", bus.result_o); end
      rst = 1'b1;
      #1;
      checks += 6;
      if (bus.busy_o !== 1'b0)     begin errors++; $display("FAIL areset_busy got=%b want=0", bus.busy_o); end
      if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL areset_ready got=%b want=0", bus.in_ready_o); end
      if (bus.result_o !== 32'd0)  begin errors++; $display("FAIL areset_result got=%h want=0", bus.result_o); end
      if (bus.function_o !== 3'b0) begin errors++; $display("FAIL areset_fn got=%b want=000", bus.function_o); end
      if (bus.opa_o !== 32'd0 || bus.opb_o !== 32'd0) begin
         errors++; $display("FAIL areset_ops got=%h/%h want=0/0", bus.opa_o, bus.opb_o);
      end
      if (bus.done_o !== 1'b0 || bus.ovf_o !== 1'b0) begin
         errors++; $display("FAIL areset_done_ovf got=%b/%b want=0/0", bus.done_o, bus.ovf_o);
      end
      #1;
      rst = 1'b0;
      bus.in_valid_i = 1'b0;
      g_smp = '{32'd2, 32'd3};
      run_red(2'b00, 2);
      checks += 2;
      if (g_res !== 32'd5)     begin errors++; $display("FAIL areset_after_result got=%0d want=5", g_res); end
      if (g_done_cyc !== 3)    begin errors++; $display("FAIL areset_after_done_cycle got=%0d want=3", g_done_cyc); end
   endtask

   task automatic test_random();
      logic [1:0]  mode;
      int          len;
      logic [31:0] exp_r;
      logic        exp_o;
      g_gap_pct = 30;
      for (int t = 0; t < 30; t++) begin
         mode = 2'($urandom_range(3));
         len  = $urandom_range(10, 1);
         g_smp.delete();
         for (int i = 0; i < len; i++) begin
            case ($urandom_range(7))
               0:       g_smp.push_back(32'h7FFF_FFFF);
               1:       g_smp.push_back(32'h8000_0000);
               2:       g_smp.push_back(32'h0);
               3:       g_smp.push_back(32'hFFFF_FFFF);
               default: g_smp.push_back($urandom);
            endcase
         end
         model(mode, exp_r, exp_o);
         run_red(mode, len);
         checks += 3;
         if (g_res !== exp_r) begin
            errors++; $display("FAIL rand%0d_result mode=%0d len=%0d got=%h want=%h", t, mode, len, g_res, exp_r);
         end
         if (g_ovf !== exp_o) begin
            errors++; $display("FAIL rand%0d_ovf mode=%0d got=%b want=%b", t, mode, g_ovf, exp_o);
         end
         if (g_done_cyc !== g_last_acc + ((mode == 2'b11) ? 2 : 1)) begin
            errors++; $display("FAIL rand%0d_done_cycle mode=%0d got=%0d want=%0d", t, mode, g_done_cyc,
                               g_last_acc + ((mode == 2'b11) ? 2 : 1));
         end
      end
      g_gap_pct = 0;
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_sum();
      test_maxmin();
      test_sumabs();
      test_ovf();
      test_len0();
      test_start_busy();
      test_abort();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
